// File: rtl/peak_frame_writer.sv
// Write-side framer for the per-channel peak FIFO: packs 16-bit peak samples
// into SYNC / SEQ / payload / checksum frames, one frame per FIFO fill-drain.
module peak_frame_writer #(
  parameter int          FRAME_LEN = 128,
  parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        peak_valid,
  input  logic [15:0] peak_data,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        wrreq,
  output logic [15:0] fifo_data,
  output logic        frame_done,
  output logic [7:0]  frame_seq,
  output logic [15:0] drop_cnt,
  output logic        frame_err
);
  localparam int PAY = FRAME_LEN - 3;
  localparam int CW  = $clog2(FRAME_LEN);

  // Each state names the word currently on fifo_data; the next word is issued
  // on the edge that leaves it (SYNC state issues the SEQ word).
  typedef enum logic [2:0] {IDLE, SYNC, DATA, CSUM, DRAIN} state_t;

  state_t        state, nxt;
  logic [15:0]   csum, csum_n, data_n, dcnt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    dif, dif_n, seq_n;
  logic          wr_n, done_n, err_n, seen_full, seen_n;
  logic          drop, start, abort;

  always_comb begin
    nxt    = state;
    wr_n   = 1'b0;
    data_n = fifo_data;
    done_n = 1'b0;
    csum_n = csum;
    cnt_n  = cnt;
    seq_n  = frame_seq;
    err_n  = frame_err;
    seen_n = seen_full;

    // A full FIFO in DATA aborts, so a coincident sample is dropped too.
    drop   = peak_valid && !(state == DATA && !fifo_full);
    dcnt_n = (drop && drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;
    dif_n  = (drop && dif != 8'hFF) ? dif + 8'd1 : dif;
    start  = fifo_empty && (state == IDLE ||
             (state == DRAIN && (seen_full || fifo_full)));
    abort  = fifo_full && (state == SYNC || state == DATA || state == CSUM);

    if (abort) begin
      err_n  = 1'b1;
      seq_n  = frame_seq + 8'd1;
      seen_n = 1'b1;
      nxt    = DRAIN;
    end else if (start) begin
      wr_n   = 1'b1;
      data_n = SYNC_WORD;
      csum_n = '0;
      seen_n = 1'b0;
      nxt    = SYNC;
    end else begin
      case (state)
        SYNC: begin
          wr_n   = 1'b1;
          data_n = {frame_seq, dif};
          csum_n = {frame_seq, dif};
          dif_n  = drop ? 8'd1 : 8'd0;
          cnt_n  = '0;
          nxt    = DATA;
        end
        DATA: if (peak_valid) begin
          wr_n   = 1'b1;
          data_n = peak_data;
          csum_n = csum + peak_data;
          cnt_n  = cnt + CW'(1);
          if (cnt == CW'(PAY - 1)) nxt = CSUM;
        end
        CSUM: begin
          wr_n   = 1'b1;
          data_n = csum;
          done_n = 1'b1;
          seq_n  = frame_seq + 8'd1;
          seen_n = 1'b0;
          nxt    = DRAIN;
        end
        DRAIN: if (fifo_full) seen_n = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      wrreq      <= 1'b0;
      fifo_data  <= '0;
      frame_done <= 1'b0;
      frame_seq  <= '0;
      drop_cnt   <= '0;
      frame_err  <= 1'b0;
      dif        <= '0;
      csum       <= '0;
      cnt        <= '0;
      seen_full  <= 1'b0;
    end else begin
      state      <= nxt;
      wrreq      <= wr_n;
      fifo_data  <= data_n;
      frame_done <= done_n;
      frame_seq  <= seq_n;
      drop_cnt   <= dcnt_n;
      frame_err  <= err_n;
      dif        <= dif_n;
      csum       <= csum_n;
      cnt        <= cnt_n;
      seen_full  <= seen_n;
    end
  end
endmodule
